// File: rtl/conv_3x3_feeder.sv
// Operand feeder for a 3x3 fp16 convolution core: collects nine pixels and
// (optionally) nine weights from a word stream, hands them to conv_3x3 and returns its result.
module conv_3x3_feeder #(
    parameter int TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [15:0]  din,
    input  logic         din_valid,
    output logic         din_ready,
    input  logic         keep_w,
    output logic [143:0] im,
    output logic [143:0] iw,
    output logic         conv_ready,
    input  logic         conv_valid,
    input  logic [15:0]  om,
    output logic [15:0]  res,
    output logic         res_valid,
    input  logic         res_ready,
    output logic         err_timeout
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_M,
        LOAD_W,
        CONV,
        OUT
    } state_t;

    state_t         r_state;
    logic [3:0]     r_cnt;
    logic           r_keep_w;
    logic [15:0]    r_im [9];
    logic [15:0]    r_iw [9];
    logic [TW-1:0]  r_tmo;
    logic           r_din_ready;
    logic           r_conv_ready;
    logic [15:0]    r_res;
    logic           r_res_valid;
    logic           r_err_timeout;

    logic           w_xfer;
    logic           w_last;
    logic           w_expire;

    assign w_xfer   = r_din_ready & din_valid;
    assign w_last   = (r_cnt == 4'd8);
    assign w_expire = (r_tmo == TW'(TIMEOUT - 1));

    // NOTE: the operand arrays sit inside the async reset on purpose: im/iw
    // must read as zero after reset, and a first job with keep_w=1 uses that zero iw.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_cnt         <= 4'd0;
            r_keep_w      <= 1'b0;
            r_tmo         <= '0;
            r_din_ready   <= 1'b0;
            r_conv_ready  <= 1'b0;
            r_res         <= 16'h0000;
            r_res_valid   <= 1'b0;
            r_err_timeout <= 1'b0;
            for (int k = 0; k < 9; k++) begin
                r_im[k] <= 16'h0000;
                r_iw[k] <= 16'h0000;
            end
        end else begin
            // NOTE: every state update uses <= so all branches see pre-edge values.
            r_err_timeout <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_din_ready <= 1'b1;
                    if (w_xfer) begin
                        r_im[0]  <= din;
                        r_keep_w <= keep_w;
                        r_cnt    <= 4'd1;
                        r_state  <= LOAD_M;
                    end
                end
                LOAD_M: begin
                    if (w_xfer) begin
                        r_im[r_cnt] <= din;
                        if (w_last) begin
                            r_cnt <= 4'd0;
                            if (r_keep_w) begin
                                r_din_ready  <= 1'b0;
                                r_conv_ready <= 1'b1;
                                r_tmo        <= '0;
                                r_state      <= CONV;
                            end else begin
                                r_state <= LOAD_W;
                            end
                        end else begin
                            r_cnt <= r_cnt + 4'd1;
                        end
                    end
                end
                LOAD_W: begin
                    if (w_xfer) begin
                        r_iw[r_cnt] <= din;
                        if (w_last) begin
                            r_cnt        <= 4'd0;
                            r_din_ready  <= 1'b0;
                            r_conv_ready <= 1'b1;
                            r_tmo        <= '0;
                            r_state      <= CONV;
                        end else begin
                            r_cnt <= r_cnt + 4'd1;
                        end
                    end
                end
                CONV: begin
                    // A result arriving on the expiry cycle takes priority over the error.
                    if (conv_valid) begin
                        r_res        <= om;
                        r_res_valid  <= 1'b1;
                        r_conv_ready <= 1'b0;
                        r_state      <= OUT;
                    end else if (w_expire) begin
                        r_err_timeout <= 1'b1;
                        r_conv_ready  <= 1'b0;
                        r_din_ready   <= 1'b1;
                        r_state       <= IDLE;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                OUT: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_din_ready <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Element 0 occupies the most significant 16 bits of each bus.
    always_comb begin
        im = '0;
        iw = '0;
        for (int k = 0; k < 9; k++) begin
            im[143 - 16*k -: 16] = r_im[k];
            iw[143 - 16*k -: 16] = r_iw[k];
        end
    end

    assign din_ready   = r_din_ready;
    assign conv_ready  = r_conv_ready;
    assign res         = r_res;
    assign res_valid   = r_res_valid;
    assign err_timeout = r_err_timeout;

endmodule

// File: tb/tb_conv_3x3_feeder.sv
// Self-checking bench for conv_3x3_feeder: directed and random jobs compared
// against an array-based operand model and cycle-count expectations.
module tb_conv_3x3_feeder;

    localparam int TIMEOUT = 64;

    logic         clk;
    logic         rst_n;
    logic [15:0]  din;
    logic         din_valid;
    logic         din_ready;
    logic         keep_w;
    logic [143:0] im;
    logic [143:0] iw;
    logic         conv_ready;
    logic         conv_valid;
    logic [15:0]  om;
    logic [15:0]  res;
    logic         res_valid;
    logic         res_ready;
    logic         err_timeout;

    int n_tests = 0;
    int n_fail  = 0;

    // Model of what conv_3x3 should currently be seeing.
    logic [15:0] m_im [9];
    logic [15:0] m_iw [9];

    conv_3x3_feeder #(.TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .din         (din),
        .din_valid   (din_valid),
        .din_ready   (din_ready),
        .keep_w      (keep_w),
        .im          (im),
        .iw          (iw),
        .conv_ready  (conv_ready),
        .conv_valid  (conv_valid),
        .om          (om),
        .res         (res),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .err_timeout (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [143:0] pack9(input logic [15:0] a [9]);
        logic [143:0] v;
        v = '0;
        for (int k = 0; k < 9; k++) v = {v[127:0], a[k]};
        return v;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 9; k++) begin
            m_im[k] = 16'h0000;
            m_iw[k] = 16'h0000;
        end
    endtask

    // Offer one word; returns after the edge on which it was accepted (+1ns).
    task automatic send_word(input logic [15:0] w, input string tag);
        bit ok;
        int waited;
        ok = 1'b0;
        waited = 0;
        din = w;
        din_valid = 1'b1;
        while (!ok && waited < 50) begin
            ok = (din_ready === 1'b1);
            @(posedge clk); #1;
            waited++;
        end
        din_valid = 1'b0;
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s send_word: din_ready never seen high within %0d cycles", tag, waited);
        end
    endtask

    task automatic load_job(input logic kw, input logic [15:0] px [9], input logic [15:0] wt [9],
                            input bit toggle, input string tag);
        int nwords;
        nwords = kw ? 9 : 18;
        for (int i = 0; i < nwords; i++) begin
            if (toggle && i > 0) begin
                din = 16'($urandom);
                din_valid = 1'b0;
                @(posedge clk); #1;
            end
            if (i == nwords - 1) begin
                n_tests++;
                if (conv_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s early_conv_ready: got %b before last word, want 0", tag, conv_ready);
                end
            end
            // keep_w only matters on the first word of the job.
            keep_w = (i == 0) ? kw : ~kw;
            send_word((i < 9) ? px[i] : wt[i - 9], tag);
        end
        keep_w = 1'b0;
        for (int k = 0; k < 9; k++) begin
            m_im[k] = px[k];
            if (!kw) m_iw[k] = wt[k];
        end
        n_tests++;
        if (conv_ready !== 1'b1 || din_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s load_done: conv_ready=%b din_ready=%b, want 1/0", tag, conv_ready, din_ready);
        end
        n_tests++;
        if (im !== pack9(m_im)) begin
            n_fail++;
            $display("FAIL %s im: got %h want %h", tag, im, pack9(m_im));
        end
        n_tests++;
        if (iw !== pack9(m_iw)) begin
            n_fail++;
            $display("FAIL %s iw: got %h want %h", tag, iw, pack9(m_iw));
        end
    endtask

    // Answer from the model core after 'delay' CONV edges, then stall downstream 'hold' cycles.
    task automatic run_conv(input int delay, input logic [15:0] r, input int hold, input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < delay; i++) begin
            @(posedge clk); #1;
            if (conv_ready !== 1'b1 || err_timeout !== 1'b0) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL %s conv_wait: conv_ready/err wrong on %0d of %0d cycles", tag, bad, delay);
        end
        conv_valid = 1'b1;
        om = r;
        @(posedge clk); #1;
        conv_valid = 1'b0;
        om = 16'($urandom);
        n_tests++;
        if (res !== r || res_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s capture: res=%h res_valid=%b, want %h/1", tag, res, res_valid, r);
        end
        n_tests++;
        if (conv_ready !== 1'b0 || err_timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL %s conv_drop: conv_ready=%b err_timeout=%b, want 0/0", tag, conv_ready, err_timeout);
        end
        bad = 0;
        res_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            if (i == 1) begin
                conv_valid = 1'b1;
                om = ~r;
            end
            @(posedge clk); #1;
            conv_valid = 1'b0;
            if (res !== r || res_valid !== 1'b1 || din_ready !== 1'b0) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL %s out_hold: res/res_valid/din_ready disturbed on %0d of %0d cycles", tag, bad, hold);
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        n_tests++;
        if (res_valid !== 1'b0 || din_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s out_exit: res_valid=%b din_ready=%b, want 0/1", tag, res_valid, din_ready);
        end
        n_tests++;
        if (im !== pack9(m_im) || iw !== pack9(m_iw)) begin
            n_fail++;
            $display("FAIL %s operands_stable: im=%h iw=%h", tag, im, iw);
        end
    endtask

    task automatic hit_reset(input string tag);
        #2 rst_n = 1'b0;
        #1;
        model_clear();
        n_tests++;
        if ({im, iw, res, conv_ready, res_valid, err_timeout, din_ready} !== '0) begin
            n_fail++;
            $display("FAIL %s reset_outputs: im=%h iw=%h res=%h cr=%b rv=%b err=%b dr=%b",
                     tag, im, iw, res, conv_ready, res_valid, err_timeout, din_ready);
        end
        din_valid = 1'b0;
        conv_valid = 1'b0;
        res_ready = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic rand_ops(output logic [15:0] a [9]);
        for (int k = 0; k < 9; k++) a[k] = 16'($urandom);
    endtask

    task automatic test_reset();
        #3;
        model_clear();
        n_tests++;
        if ({im, iw, res, conv_ready, res_valid, err_timeout, din_ready} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: im=%h iw=%h res=%h cr=%b rv=%b err=%b dr=%b",
                     im, iw, res, conv_ready, res_valid, err_timeout, din_ready);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (din_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release: din_ready=%b, want 1", din_ready);
        end
    endtask

    task automatic test_full_load();
        logic [15:0] v [9];
        v = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400, 16'h4500,
              16'h4600, 16'h4700, 16'h4800, 16'h4880};
        load_job(1'b0, v, v, 1'b0, "full_load");
        n_tests++;
        if (im !== 144'h3C00_4000_4200_4400_4500_4600_4700_4800_4880 ||
            iw !== 144'h3C00_4000_4200_4400_4500_4600_4700_4800_4880) begin
            n_fail++;
            $display("FAIL full_load_literal: im=%h iw=%h", im, iw);
        end
        run_conv(10, 16'h5C74, 5, "full_load");
    endtask

    task automatic test_keep_w();
        logic [15:0] px [9];
        logic [15:0] wt [9];
        for (int k = 0; k < 9; k++) px[k] = 16'h3C00;
        rand_ops(wt);
        load_job(1'b1, px, wt, 1'b0, "keep_w");
        run_conv(3, 16'($urandom), 1, "keep_w");
    endtask

    task automatic test_toggle();
        logic [15:0] px [9];
        logic [15:0] wt [9];
        rand_ops(px);
        rand_ops(wt);
        load_job(1'b0, px, wt, 1'b1, "toggle");
        run_conv(2, 16'($urandom), 2, "toggle");
    endtask

    task automatic test_timeout();
        logic [15:0] px [9];
        logic [15:0] wt [9];
        int n;
        int bad;
        rand_ops(px);
        rand_ops(wt);
        load_job(1'b0, px, wt, 1'b0, "timeout");
        n = 0;
        bad = 0;
        while (conv_ready === 1'b1 && n < 4 * TIMEOUT) begin
            if (err_timeout !== 1'b0) bad++;
            @(posedge clk); #1;
            n++;
        end
        n_tests++;
        if (n != TIMEOUT || bad != 0) begin
            n_fail++;
            $display("FAIL timeout_len: conv_ready high %0d cycles (early err %0d), want %0d", n, bad, TIMEOUT);
        end
        n_tests++;
        if (err_timeout !== 1'b1 || res_valid !== 1'b0 || din_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_pulse: err=%b res_valid=%b din_ready=%b, want 1/0/1",
                     err_timeout, res_valid, din_ready);
        end
        @(posedge clk); #1;
        n_tests++;
        if (err_timeout !== 1'b0 || din_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_single: err=%b din_ready=%b, want 0/1", err_timeout, din_ready);
        end
    endtask

    task automatic test_timeout_race();
        logic [15:0] px [9];
        logic [15:0] wt [9];
        rand_ops(px);
        rand_ops(wt);
        load_job(1'b0, px, wt, 1'b0, "race");
        run_conv(TIMEOUT - 1, 16'($urandom), 1, "race");
    endtask

    task automatic test_reset_midjob();
        logic [15:0] px [9];
        logic [15:0] wt [9];
        rand_ops(px);
        rand_ops(wt);
        keep_w = 1'b0;
        for (int i = 0; i < 13; i++) send_word((i < 9) ? px[i] : wt[i - 9], "mid_load_w");
        hit_reset("mid_load_w");
        rand_ops(px);
        rand_ops(wt);
        load_job(1'b1, px, wt, 1'b0, "post_reset_keep");
        run_conv(1, 16'($urandom), 0, "post_reset_keep");
        rand_ops(px);
        rand_ops(wt);
        load_job(1'b0, px, wt, 1'b0, "mid_conv");
        hit_reset("mid_conv");
        rand_ops(px);
        rand_ops(wt);
        load_job(1'b0, px, wt, 1'b0, "after_reset");
        run_conv(5, 16'($urandom), 2, "after_reset");
    endtask

    task automatic test_back_to_back();
        logic [15:0] px [9];
        logic [15:0] wt [9];
        for (int j = 0; j < 6; j++) begin
            rand_ops(px);
            rand_ops(wt);
            load_job(1'($urandom), px, wt, 1'($urandom), $sformatf("b2b%0d", j));
            run_conv(int'($urandom_range(0, 20)), 16'($urandom), int'($urandom_range(0, 3)),
                     $sformatf("b2b%0d", j));
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        din        = 16'h0000;
        din_valid  = 1'b0;
        keep_w     = 1'b0;
        conv_valid = 1'b0;
        om         = 16'h0000;
        res_ready  = 1'b0;
        test_reset();
        test_full_load();
        test_keep_w();
        test_toggle();
        test_timeout();
        test_timeout_race();
        test_reset_midjob();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
